// File: rtl/pcileech_led_ctl.sv
// Status-LED controller: per-channel OFF/ON/BLINK/BLINK_INV/ACTIVITY/HEARTBEAT modes off a shared ms prescaler.
// Optional per-channel PWM brightness is enabled with `define PCILEECH_LED_PWM_EN.
module pcileech_led_ctl #(
  parameter int NUM_LEDS      = 6,
  parameter int TICK_DIV      = 100000,
  parameter int BLINK_HALF_MS = 250,
  parameter int STRETCH_MS    = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3*NUM_LEDS-1:0]   cfg_mode,
  input  logic [NUM_LEDS-1:0]     cfg_invert,
  input  logic [NUM_LEDS-1:0]     act,
`ifdef PCILEECH_LED_PWM_EN
  input  logic [4*NUM_LEDS-1:0]   cfg_duty,
`endif
  output logic                    tick,
  output logic [NUM_LEDS-1:0]     led
);

  typedef enum logic [2:0] {
    MODE_OFF       = 3'd0,
    MODE_ON        = 3'd1,
    MODE_BLINK     = 3'd2,
    MODE_BLINK_INV = 3'd3,
    MODE_ACTIVITY  = 3'd4,
    MODE_HEARTBEAT = 3'd5
  } led_mode_e;

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int BLK_W = $clog2(BLINK_HALF_MS);
  localparam int STR_W = $clog2(STRETCH_MS + 1);

  localparam logic [PRE_W-1:0] PRE_MAX      = PRE_W'(TICK_DIV - 1);
  localparam logic [BLK_W-1:0] BLINK_MAX    = BLK_W'(BLINK_HALF_MS - 1);
  localparam logic [BLK_W-1:0] HB_LIM       = BLK_W'(BLINK_HALF_MS / 4);
  localparam logic [STR_W-1:0] STRETCH_LOAD = STR_W'(STRETCH_MS);

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic                tick_q, tick_d;
  logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [STR_W-1:0]    stretch_q [NUM_LEDS];
  logic [STR_W-1:0]    stretch_d [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [NUM_LEDS-1:0] on_vec;
  logic                hb_on;
`ifdef PCILEECH_LED_PWM_EN
  logic [3:0]          pwm_cnt_q, pwm_cnt_d;
  logic [3:0]          duty;
`endif

  always_comb begin
    pre_cnt_d     = (pre_cnt_q == PRE_MAX) ? '0 : pre_cnt_q + PRE_W'(1);
    tick_d        = (pre_cnt_q == PRE_MAX);
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (tick_q) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
    hb_on = ~blink_phase_q && (blink_cnt_q < HB_LIM);
  end

  // Stretch counters run in every mode so switching into ACTIVITY reflects recent traffic.
  always_comb begin
    on_vec = '0;
    led_d  = '0;
`ifdef PCILEECH_LED_PWM_EN
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    duty      = '0;
`endif
    for (int i = 0; i < NUM_LEDS; i++) begin
      stretch_d[i] = stretch_q[i];
      if (act[i]) begin
        stretch_d[i] = STRETCH_LOAD;
      end else if (tick_q && (stretch_q[i] != '0)) begin
        stretch_d[i] = stretch_q[i] - STR_W'(1);
      end

      case (led_mode_e'(cfg_mode[3*i +: 3]))
        MODE_ON:        on_vec[i] = 1'b1;
        MODE_BLINK:     on_vec[i] = blink_phase_q;
        MODE_BLINK_INV: on_vec[i] = ~blink_phase_q;
        MODE_ACTIVITY:  on_vec[i] = (stretch_q[i] != '0) || act[i];
        MODE_HEARTBEAT: on_vec[i] = hb_on;
        default:        on_vec[i] = 1'b0;
      endcase

`ifdef PCILEECH_LED_PWM_EN
      duty = cfg_duty[4*i +: 4];
      if (!((duty == 4'd15) || (pwm_cnt_q < duty))) begin
        on_vec[i] = 1'b0;
      end
`endif
      led_d[i] = on_vec[i] ^ cfg_invert[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q     <= '0;
      tick_q        <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      stretch_q     <= '{default: '0};
      led_q         <= '0;
`ifdef PCILEECH_LED_PWM_EN
      pwm_cnt_q     <= '0;
`endif
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      tick_q        <= tick_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      stretch_q     <= stretch_d;
      led_q         <= led_d;
`ifdef PCILEECH_LED_PWM_EN
      pwm_cnt_q     <= pwm_cnt_d;
`endif
    end
  end

  assign tick = tick_q;
  assign led  = led_q;

endmodule

// File: tb/tb_pcileech_led_ctl.sv
// Randomized self-checking bench for pcileech_led_ctl against a closed-form timing model.
// The PWM scenario is exercised only when PCILEECH_LED_PWM_EN is defined.
module tb_pcileech_led_ctl;

  localparam int N  = 2;
  localparam int TD = 4;
  localparam int BH = 4;
  localparam int S  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3*N-1:0] cfg_mode = '0;
  logic [N-1:0]   cfg_invert = '0;
  logic [N-1:0]   act = '0;
`ifdef PCILEECH_LED_PWM_EN
  logic [4*N-1:0] cfg_duty = '1;
`endif
  logic           tick;
  logic [N-1:0]   led;

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release, and the edge of each channel's last act.
  int           edges = 0;
  logic [N-1:0] has_act = '0;
  int           last_act [N];
  logic [N-1:0] exp_led;
  logic         exp_tick;

  pcileech_led_ctl #(
    .NUM_LEDS(N),
    .TICK_DIV(TD),
    .BLINK_HALF_MS(BH),
    .STRETCH_MS(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_mode(cfg_mode),
    .cfg_invert(cfg_invert),
    .act(act),
`ifdef PCILEECH_LED_PWM_EN
    .cfg_duty(cfg_duty),
`endif
    .tick(tick),
    .led(led)
  );

  always #5 clk = ~clk;

  // Number of tick pulses consumed by the blink/stretch logic after s edges.
  function automatic int ticks_at(int s);
    return (s >= 1) ? (s - 1) / TD : 0;
  endfunction

  function automatic logic phase_at(int s);
    return ((ticks_at(s) / BH) % 2) == 1;
  endfunction

  // Predicts outputs after the next edge from current inputs, then clocks once.
  task automatic advance();
    int   k;
    int   cnt;
    logic ph;
    logic on;
`ifdef PCILEECH_LED_PWM_EN
    logic [3:0] d;
`endif
    if (rst) begin
      exp_led  = '0;
      exp_tick = 1'b0;
    end else begin
      k        = ticks_at(edges);
      ph       = ((k / BH) % 2) == 1;
      cnt      = k % BH;
      exp_tick = ((edges + 1) % TD) == 0;
      for (int i = 0; i < N; i++) begin
        case (cfg_mode[3*i +: 3])
          3'd1:    on = 1'b1;
          3'd2:    on = ph;
          3'd3:    on = !ph;
          3'd4:    on = act[i] || (has_act[i] && ((k - ticks_at(last_act[i])) < S));
          3'd5:    on = !ph && (cnt < BH / 4);
          default: on = 1'b0;
        endcase
`ifdef PCILEECH_LED_PWM_EN
        d = cfg_duty[4*i +: 4];
        if (!((d == 4'd15) || ((edges % 16) < int'(d)))) on = 1'b0;
`endif
        exp_led[i] = on ^ cfg_invert[i];
      end
    end
    @(posedge clk);
    if (rst) begin
      edges   = 0;
      has_act = '0;
    end else begin
      edges++;
      for (int i = 0; i < N; i++) begin
        if (act[i]) begin
          has_act[i]  = 1'b1;
          last_act[i] = edges;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    cfg_invert = 2'b11;
    for (int c = 0; c < 5; c++) begin
      cfg_mode = 6'($urandom_range(0, 63));
      act      = 2'($urandom_range(0, 3));
      advance();
      checks++;
      if (led !== 2'b00) begin
        errors++;
        $display("[TB] FAIL reset_led got=%b want=00", led);
      end
      checks++;
      if (tick !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_tick got=%b want=0", tick);
      end
    end
    rst      = 1'b0;
    cfg_mode = '0;
    act      = '0;
    advance();
    checks++;
    if (led !== 2'b11) begin
      errors++;
      $display("[TB] FAIL reset_release_led got=%b want=11", led);
    end
  endtask

  task automatic test_blink();
    int highs = 0;
    cfg_invert = '0;
    act        = '0;
    cfg_mode   = {3'd0, 3'd2};
    for (int c = 0; c < 96; c++) begin
      cfg_mode[5:3] = 3'($urandom_range(0, 7));
      advance();
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("[TB] FAIL blink_led edge=%0d got=%b want=%b", edges, led, exp_led);
      end
      checks++;
      if (tick !== exp_tick) begin
        errors++;
        $display("[TB] FAIL blink_tick edge=%0d got=%b want=%b", edges, tick, exp_tick);
      end
      if (c >= 64) highs += int'(led[0]);
    end
    checks++;
    if (highs != 16) begin
      errors++;
      $display("[TB] FAIL blink_duty highs=%0d want=16", highs);
    end
  endtask

  task automatic test_activity();
    cfg_invert = '0;
    cfg_mode   = {3'd4, 3'd4};
    for (int c = 0; c < 150; c++) begin
      act[1] = ($urandom_range(0, 11) == 0);
      act[0] = ($urandom_range(0, 3) == 0);
      if (c >= 120) act = '0;
      advance();
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("[TB] FAIL activity_led edge=%0d got=%b want=%b", edges, led, exp_led);
      end
    end
    checks++;
    if (led !== 2'b00) begin
      errors++;
      $display("[TB] FAIL activity_expire got=%b want=00", led);
    end
  endtask

  task automatic test_heartbeat();
    int highs = 0;
    act        = '0;
    cfg_invert = 2'($urandom_range(0, 3));
    cfg_mode   = {3'd5, 3'd5};
    for (int c = 0; c < 64; c++) begin
      advance();
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("[TB] FAIL heartbeat_led edge=%0d got=%b want=%b", edges, led, exp_led);
      end
      highs += int'(led[0] ^ cfg_invert[0]);
    end
    checks++;
    if (highs != 8) begin
      errors++;
      $display("[TB] FAIL heartbeat_duty highs=%0d want=8", highs);
    end
    cfg_invert = '0;
    cfg_mode   = {3'd7, 3'd6};
    for (int c = 0; c < 40; c++) begin
      advance();
      checks++;
      if (led !== 2'b00) begin
        errors++;
        $display("[TB] FAIL reserved_led edge=%0d got=%b want=00", edges, led);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lows = 0;
    cfg_invert = '0;
    cfg_mode   = {3'd3, 3'd2};
    for (int c = 0; c < 64 && !phase_at(edges); c++) advance();
    checks++;
    if (!phase_at(edges)) begin
      errors++;
      $display("[TB] FAIL reset_mid_phase got=0 want=1");
    end
    rst = 1'b1;
    advance();
    checks++;
    if (led !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_mid_led got=%b want=00", led);
    end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      advance();
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("[TB] FAIL reset_mid_run edge=%0d got=%b want=%b", edges, led, exp_led);
      end
      if (c < 16) lows += int'(!led[0]);
    end
    checks++;
    if (lows != 16) begin
      errors++;
      $display("[TB] FAIL reset_mid_halfperiod lows=%0d want=16", lows);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      rst        = ($urandom_range(0, 59) == 0);
      cfg_mode   = 6'($urandom_range(0, 63));
      cfg_invert = 2'($urandom_range(0, 3));
      act        = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
`ifdef PCILEECH_LED_PWM_EN
      cfg_duty   = 8'($urandom_range(0, 255));
`endif
      advance();
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("[TB] FAIL b2b_led edge=%0d got=%b want=%b", edges, led, exp_led);
      end
      checks++;
      if (tick !== exp_tick) begin
        errors++;
        $display("[TB] FAIL b2b_tick edge=%0d got=%b want=%b", edges, tick, exp_tick);
      end
    end
    rst = 1'b0;
`ifdef PCILEECH_LED_PWM_EN
    cfg_duty = '1;
`endif
  endtask

`ifdef PCILEECH_LED_PWM_EN
  task automatic test_pwm();
    logic [3:0] duties [3] = '{4'd4, 4'd0, 4'd15};
    int         wants  [3] = '{4, 0, 16};
    int         highs;
    act        = '0;
    cfg_invert = '0;
    cfg_mode   = {3'd1, 3'd1};
    for (int j = 0; j < 3; j++) begin
      highs    = 0;
      cfg_duty = {4'($urandom_range(0, 15)), duties[j]};
      for (int c = 0; c < 32; c++) begin
        advance();
        checks++;
        if (led !== exp_led) begin
          errors++;
          $display("[TB] FAIL pwm_led edge=%0d got=%b want=%b", edges, led, exp_led);
        end
        if (c >= 16) highs += int'(led[0]);
      end
      checks++;
      if (highs != wants[j]) begin
        errors++;
        $display("[TB] FAIL pwm_duty duty=%0d highs=%0d want=%0d", duties[j], highs, wants[j]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_blink();
    test_activity();
    test_heartbeat();
    test_reset_mid();
`ifdef PCILEECH_LED_PWM_EN
    test_pwm();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
